// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the byte-serial memory arbiter
package mem_arbiter_pkg;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;
  localparam int InstAddrBus = 32;

  typedef enum logic [1:0] {
    SizeByte = 2'b00,
    SizeHalf = 2'b01,
    SizeWord = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IF_RD  = 2'b01,
    MEM_RD = 2'b10,
    MEM_WR = 2'b11
  } arb_state_e;

  // Encoding 2'b11 is treated as a full word, like SizeWord.
  function automatic int unsigned size_bytes(input logic [1:0] size, input int unsigned word_bytes);
    case (size)
      SizeByte: return 1;
      SizeHalf: return 2;
      default:  return word_bytes;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates fetch and load/store onto one byte-wide RAM, little-endian beats
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = InstAddrBus,
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_W-1:0]       if_addr,
  input  logic                    if_flush,
  output logic [8*WORD_BYTES-1:0] if_data,
  output logic                    if_done,
  input  logic                    mem_req,
  input  logic                    mem_we,
  input  logic [1:0]              mem_size,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [8*WORD_BYTES-1:0] mem_wdata,
  output logic [8*WORD_BYTES-1:0] mem_rdata,
  output logic                    mem_done,
  output logic                    mem_busy,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [7:0]              ram_wdata,
  output logic                    ram_we,
  input  logic [7:0]              ram_rdata
);

  localparam int DATA_W = 8 * WORD_BYTES;
  localparam int CNT_W  = $clog2(WORD_BYTES + 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic [DATA_W-1:0] if_data_d, mem_rdata_d;
  logic              if_done_d, mem_done_d;
  logic [DATA_W-1:0] assembled;
  logic [CNT_W-1:0]  lane;

  assign mem_busy = mem_req & ~mem_done;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    if_done_d   = False;
    mem_done_d  = False;
    if_data_d   = if_data;
    mem_rdata_d = mem_rdata;
    ram_addr    = '0;
    ram_wdata   = '0;
    ram_we      = False;

    // The byte addressed last cycle lands in lane cnt-1.
    lane      = cnt_q - CNT_W'(1);
    assembled = rbuf_q;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (cnt_q != '0 && CNT_W'(i) == lane) assembled[i*8 +: 8] = ram_rdata;
    end

    case (state_q)
      IDLE: begin
        if (mem_req && !mem_done) begin
          state_d = mem_we ? MEM_WR : MEM_RD;
          cnt_d   = '0;
          len_d   = CNT_W'(size_bytes(mem_size, WORD_BYTES));
          base_d  = mem_addr;
          wdata_d = mem_wdata;
          rbuf_d  = '0;
        end else if (if_req && !if_done && !if_flush) begin
          state_d = IF_RD;
          cnt_d   = '0;
          len_d   = CNT_W'(WORD_BYTES);
          base_d  = if_addr;
          rbuf_d  = '0;
        end
      end

      IF_RD, MEM_RD: begin
        if (cnt_q < len_q) ram_addr = base_q + ADDR_W'(cnt_q);
        rbuf_d = assembled;
        cnt_d  = cnt_q + CNT_W'(1);
        if (state_q == IF_RD && if_flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == len_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (state_q == IF_RD) begin
            if_done_d = True;
            if_data_d = assembled;
          end else begin
            mem_done_d  = True;
            mem_rdata_d = assembled;
          end
        end
      end

      MEM_WR: begin
        ram_addr  = base_q + ADDR_W'(cnt_q);
        ram_wdata = 8'(wdata_q >> {cnt_q, 3'b000});
        ram_we    = True;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == len_q - CNT_W'(1)) begin
          state_d    = IDLE;
          cnt_d      = '0;
          mem_done_d = True;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      base_q    <= '0;
      wdata_q   <= '0;
      rbuf_q    <= '0;
      if_done   <= False;
      mem_done  <= False;
      if_data   <= '0;
      mem_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      base_q    <= base_d;
      wdata_q   <= wdata_d;
      rbuf_q    <= rbuf_d;
      if_done   <= if_done_d;
      mem_done  <= mem_done_d;
      if_data   <= if_data_d;
      mem_rdata <= mem_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush;
  logic [31:0] if_addr, if_data;
  logic        if_done;
  logic        mem_req, mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done, mem_busy;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;
  logic        ram_we;

  logic [7:0]  ram [0:255];
  logic        pl_en;
  logic [7:0]  pl_addr, pl_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_busy(mem_busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  // 256-byte RAM aliased on the low address byte; registered read.
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (ram_we) ram[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= ram[ram_addr[7:0]];
  end

  task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL reset_if_done got=%b exp=0", if_done); end
    checks++; if (mem_done !== 1'b0) begin failures++; $display("FAIL reset_mem_done got=%b exp=0", mem_done); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
    checks++; if (ram_addr !== 32'h0) begin failures++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
    checks++; if (if_data !== 32'h0 || mem_rdata !== 32'h0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", if_data, mem_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_fetch;
    int got = -1;
    logic [31:0] d = '0;
    load_byte(8'h00, 8'h13); load_byte(8'h01, 8'h05);
    load_byte(8'h02, 8'h10); load_byte(8'h03, 8'h00);
    if_req = 1'b1; if_addr = 32'h100;
    for (int j = 0; j < 12 && got < 0; j++) begin
      @(negedge clk);
      if (j < 4) begin
        checks++;
        if (ram_addr !== 32'h100 + j) begin failures++; $display("FAIL fetch_addr%0d got=%h exp=%h", j, ram_addr, 32'h100 + j); end
      end
      if (if_done) begin got = j; d = if_data; if_req = 1'b0; end
    end
    checks++; if (got !== 5) begin failures++; $display("FAIL fetch_latency got=%0d exp=5", got); end
    checks++; if (d !== 32'h00100513) begin failures++; $display("FAIL fetch_data got=%h exp=00100513", d); end
    @(negedge clk);
    checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL fetch_done_width got=%b exp=0", if_done); end
  endtask

  task automatic test_simultaneous;
    int mg = -1, ig = -1;
    logic [31:0] md = '0, id = '0;
    load_byte(8'h20, 8'hAB);
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'h20;
    #1;
    checks++; if (mem_busy !== 1'b1) begin failures++; $display("FAIL sim_busy got=%b exp=1", mem_busy); end
    for (int j = 0; j < 16 && ig < 0; j++) begin
      @(negedge clk);
      if (j == 3) begin
        checks++;
        if (ram_addr !== 32'h100 || mem_done !== 1'b0) begin failures++; $display("FAIL sim_if_grant got=%h/%b exp=00000100/0", ram_addr, mem_done); end
      end
      if (mem_done && mg < 0) begin mg = j; md = mem_rdata; mem_req = 1'b0; end
      if (if_done) begin ig = j; id = if_data; if_req = 1'b0; end
    end
    checks++; if (mg !== 2) begin failures++; $display("FAIL sim_mem_latency got=%0d exp=2", mg); end
    checks++; if (md !== 32'h000000AB) begin failures++; $display("FAIL sim_mem_rdata got=%h exp=000000ab", md); end
    checks++; if (ig !== 8) begin failures++; $display("FAIL sim_if_latency got=%0d exp=8", ig); end
    checks++; if (id !== 32'h00100513) begin failures++; $display("FAIL sim_if_data got=%h exp=00100513", id); end
  endtask

  task automatic test_word_store;
    logic [7:0] exp_b [4];
    int nwe = 0, ndone = 0, first = -1;
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load_byte(8'h44, 8'h5A);
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h40; mem_wdata = 32'hDEADBEEF;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (ram_we) begin
        checks++;
        if (nwe > 3 || ram_addr !== 32'h40 + nwe || ram_wdata !== exp_b[nwe[1:0]]) begin
          failures++; $display("FAIL store_beat%0d got=%h:%h", nwe, ram_addr, ram_wdata);
        end
        nwe++;
      end
      if (mem_done) begin ndone++; if (first < 0) first = j; mem_req = 1'b0; end
    end
    checks++; if (nwe !== 4) begin failures++; $display("FAIL store_we_cycles got=%0d exp=4", nwe); end
    checks++; if (ndone !== 1 || first !== 4) begin failures++; $display("FAIL store_done got=%0d@%0d exp=1@4", ndone, first); end
    checks++; if ({ram[8'h43], ram[8'h42], ram[8'h41], ram[8'h40]} !== 32'hDEADBEEF) begin
      failures++; $display("FAIL store_ram got=%h exp=deadbeef", {ram[8'h43], ram[8'h42], ram[8'h41], ram[8'h40]});
    end
    checks++; if (ram[8'h44] !== 8'h5A) begin failures++; $display("FAIL store_untouched got=%h exp=5a", ram[8'h44]); end
  endtask

  task automatic test_flush;
    int got = -1, early = 0;
    logic [31:0] d = '0;
    load_byte(8'h80, 8'h11); load_byte(8'h81, 8'h22);
    load_byte(8'h82, 8'h33); load_byte(8'h83, 8'h44);
    if_req = 1'b1; if_addr = 32'h100;
    for (int j = 0; j < 16 && got < 0; j++) begin
      @(negedge clk);
      if (j == 2) begin if_flush = 1'b1; if_addr = 32'h180; end
      if (j == 3) begin
        if_flush = 1'b0;
        checks++; if (ram_addr !== 32'h0) begin failures++; $display("FAIL flush_idle got=%h exp=0", ram_addr); end
      end
      if (j == 4) begin
        checks++; if (ram_addr !== 32'h180) begin failures++; $display("FAIL flush_refetch got=%h exp=00000180", ram_addr); end
      end
      if (if_done) begin
        if (j < 9) early++;
        got = j; d = if_data; if_req = 1'b0;
      end
    end
    checks++; if (early !== 0 || got !== 9) begin failures++; $display("FAIL flush_done got=%0d early=%0d exp=9", got, early); end
    checks++; if (d !== 32'h44332211) begin failures++; $display("FAIL flush_data got=%h exp=44332211", d); end
  endtask

  task automatic test_reset_mid_store;
    int bad = 0;
    load_byte(8'h60, 8'hFF); load_byte(8'h61, 8'hFF); load_byte(8'h62, 8'h00);
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h60; mem_wdata = 32'h01020304;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_req = 1'b0;
    checks++; if (ram_we !== 1'b0 || ram_addr !== 32'h0 || if_data !== 32'h0 || mem_rdata !== 32'h0 || if_done !== 1'b0) begin
      failures++; $display("FAIL rst_outputs got=%b %h %h %h %b exp=0", ram_we, ram_addr, if_data, mem_rdata, if_done);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j == 1) rst = 1'b0;
      if (mem_done || ram_we) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", bad); end
    checks++; if ({ram[8'h62], ram[8'h61], ram[8'h60]} !== 24'h000304) begin
      failures++; $display("FAIL rst_ram got=%h exp=000304", {ram[8'h62], ram[8'h61], ram[8'h60]});
    end
  endtask

  task automatic test_half_wrap;
    int got = -1;
    logic [31:0] d = '0;
    load_byte(8'hFF, 8'h34); load_byte(8'h00, 8'h12);
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b01; mem_addr = 32'hFFFFFFFF;
    for (int j = 0; j < 10 && got < 0; j++) begin
      @(negedge clk);
      if (j == 0) begin
        checks++; if (ram_addr !== 32'hFFFFFFFF) begin failures++; $display("FAIL wrap_addr0 got=%h exp=ffffffff", ram_addr); end
      end
      if (j == 1) begin
        checks++; if (ram_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr1 got=%h exp=0", ram_addr); end
      end
      if (mem_done) begin got = j; d = mem_rdata; mem_req = 1'b0; end
    end
    checks++; if (got !== 3) begin failures++; $display("FAIL wrap_latency got=%0d exp=3", got); end
    checks++; if (d !== 32'h00001234) begin failures++; $display("FAIL wrap_rdata got=%h exp=00001234", d); end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_addr = '0; mem_wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    test_reset;
    test_fetch;
    test_simultaneous;
    test_word_store;
    test_flush;
    test_reset_mid_store;
    test_half_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
